alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; legal values are even and at least 8.
REQ-002 SHALL have: clk_i  in  1  the one clock; all state updates on its rising edge.
REQ-003 SHALL have: rst_ni  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: flush_i  in  1  synchronous abort of any operation in flight.
REQ-005 SHALL have: in_valid_i  in  1  request valid; in_ready_o  out  1  request accepted when both high at an edge.
REQ-006 SHALL have: op_i  in  5  operation code (REQ-010/011); operand_a_i, operand_b_i  in  WIDTH  operands.
REQ-007 SHALL have: out_valid_o  out  1  result valid; out_ready_i  in  1  result consumed when both high at an edge.
REQ-008 SHALL have: result_o  out  WIDTH  result; div_by_zero_o  out  1  result came from divide/remainder with b=0.
REQ-009 SHALL have: busy_o  out  1  high whenever state is not IDLE.

Function
REQ-010 op_i[4]=0 (base): 0 ADD, 1 SUB, 2 SLT signed, 3 SLTU unsigned, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10-15 pass operand_b (LUI).
REQ-011 op_i[4]=1 (M-ext, op_i[2:0]): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; op_i[3] ignored.
REQ-012 Shift amount SHALL be operand_b[$clog2(WIDTH)-1:0]; SLT/SLTU SHALL be zero-extended 0/1; SLTU with b=0 SHALL be 0.
REQ-013 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; MULH* SHALL return bits [2*WIDTH-1:WIDTH] of the exact 2*WIDTH-bit product, signedness per op (MULHSU: a signed, b unsigned).
REQ-014 FSM states SHALL be IDLE, CALC, DONE; in_ready_o SHALL be 1 only in IDLE and flush_i=0.
REQ-015 IDLE + accept of base op SHALL go to DONE with result registered at that edge (latency 1 edge to out_valid_o).
REQ-016 IDLE + accept of MUL* or normal DIV/REM SHALL go to CALC, load an iteration counter with WIDTH, and perform one radix-2 shift-add (mul) or restoring shift-subtract (div) step per edge.
REQ-017 CALC SHALL go to DONE at the edge the counter reaches 0, i.e. out_valid_o rises exactly WIDTH+1 edges after the accept edge.
REQ-018 Signed DIV/REM SHALL operate on magnitudes and fix signs at the final step: quotient negative iff signs differ, remainder takes the dividend sign.
REQ-019 Divide by zero SHALL bypass CALC (latency 1): quotient all-ones, remainder = operand_a, div_by_zero_o=1.
REQ-020 Signed overflow (a = most-negative, b = -1, DIV/REM) SHALL bypass CALC (latency 1): quotient = a, remainder = 0.
REQ-021 DONE SHALL hold out_valid_o=1 and result_o, div_by_zero_o stable until out_ready_i=1 at an edge, then go to IDLE.
REQ-022 out_valid_o SHALL be 0 and div_by_zero_o SHALL be 0 in IDLE and CALC; result_o SHALL hold its last value outside DONE.
REQ-023 Operands and op SHALL be captured at accept; input changes during CALC/DONE SHALL not affect the result.
REQ-024 flush_i=1 at an edge SHALL force IDLE from any state, drop any pending result, and accept nothing that edge (flush wins over in_valid_i and out_ready_i).
REQ-025 in_valid_i high while in_ready_o=0 SHALL be ignored; no request SHALL be queued.

Reset
REQ-026 rst_ni=0 SHALL immediately force IDLE, out_valid_o=0, div_by_zero_o=0, busy_o=0, result_o=0, counter=0, regardless of clock.
REQ-027 Reset asserted mid-CALC or mid-DONE SHALL abort the operation; no result SHALL appear after release.
REQ-028 First accept SHALL be possible at the first rising edge after rst_ni deasserts.

Verification
REQ-029 WIDTH=32, SLTU a=1 b=0xFFFFFFFF -> 1 edge later out_valid_o=1, result_o=1; SLT same operands -> result_o=0.
REQ-030 WIDTH=32, MULH a=0x80000000 b=0x80000000 -> out_valid_o after exactly 33 edges, result_o=0x40000000; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
REQ-031 WIDTH=32, DIV a=-7 b=2 -> result_o=0xFFFFFFFD after 33 edges; REM same -> 0xFFFFFFFF; DIVU a=5 b=0 -> 1 edge, 0xFFFFFFFF, div_by_zero_o=1.
REQ-032 DIV a=0x80000000 b=0xFFFFFFFF -> 1 edge, result_o=0x80000000; REM same -> 0.
REQ-033 out_ready_i held 0 for 5 edges in DONE -> out_valid_o and result_o stable throughout, in_ready_o=0; then 1 -> IDLE next edge.
REQ-034 flush_i pulsed at CALC edge 10 with in_valid_i=1 -> IDLE, out_valid_o never rises, request not accepted; rst_ni low mid-CALC -> outputs zero at once.

Source files
------------

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle for the ALU/MDU block.
//   slave  : seen from the ALU/MDU (requests in, results out)
//   master : seen from the requester (requests out, results in)
// Signals:
//   flush_i        abort any operation in flight (synchronous)
//   in_valid_i     request valid; accepted with in_ready_o at a rising edge
//   op_i           operation code
//   operand_a_i/_b_i  operands
//   in_ready_o     block can accept a request this edge
//   out_valid_o    result valid; consumed with out_ready_i at a rising edge
//   out_ready_i    requester takes the result
//   result_o       result value
//   div_by_zero_o  result came from divide/remainder by zero
//   busy_o         block is not idle
interface alu_mdu_if #(
   parameter int unsigned WIDTH = 32
);
   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [4:0]       op_i;
   logic [WIDTH-1:0] operand_a_i;
   logic [WIDTH-1:0] operand_b_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] result_o;
   logic             div_by_zero_o;
   logic             busy_o;

   modport slave (
      input  flush_i, in_valid_i, op_i, operand_a_i, operand_b_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, div_by_zero_o, busy_o
   );

   modport master (
      output flush_i, in_valid_i, op_i, operand_a_i, operand_b_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, div_by_zero_o, busy_o
   );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-issue integer ALU plus iterative multiply/divide unit.
// Base ops complete one edge after accept; MUL*/DIV*/REM* iterate one bit per
// edge (radix-2 shift-add / restoring shift-subtract) on operand magnitudes
// and fix the sign at the last step. Divide-by-zero and signed overflow
// bypass the iteration.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     alu_mdu_if slave modport (handshake, operands, result, status)
module alu_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input logic      clk_i,
   input logic      rst_ni,
   alu_mdu_if.slave bus
);

   localparam int unsigned ShW  = $clog2(WIDTH);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q, mcand_q;
   logic               neg_q, is_div_q, sel_hi_q;
   logic [WIDTH-1:0]   result_q;
   logic               out_valid_q, dbz_q, busy_q;

   // Accept-time decode
   logic [WIDTH-1:0]   a, b, base_res, a_mag, b_mag, special_res;
   logic [ShW-1:0]     sh;
   logic [2:0]         funct;
   logic               is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
   logic               div_zero, div_ovf, neg_init, sel_hi_init;

   always_comb begin
      a  = bus.operand_a_i;
      b  = bus.operand_b_i;
      sh = b[ShW-1:0];
      base_res = b;
      case (bus.op_i[3:0])
         4'd0:    base_res = a + b;
         4'd1:    base_res = a - b;
         4'd2:    base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'd3:    base_res = {{(WIDTH-1){1'b0}}, a < b};
         4'd4:    base_res = a ^ b;
         4'd5:    base_res = a | b;
         4'd6:    base_res = a & b;
         4'd7:    base_res = a << sh;
         4'd8:    base_res = a >> sh;
         4'd9:    base_res = WIDTH'($signed(a) >>> sh);
         default: base_res = b;
      endcase

      funct  = bus.op_i[2:0];
      is_div = funct[2];
      is_rem = funct[1];
      // DIV/REM are signed on even codes; MULH is s*s, MULHSU is s*u
      a_signed = is_div ? ~funct[0] : (funct == 3'd1 || funct == 3'd2);
      b_signed = is_div ? ~funct[0] : (funct == 3'd1);
      a_neg    = a_signed & a[WIDTH-1];
      b_neg    = b_signed & b[WIDTH-1];
      a_mag    = a_neg ? (~a + 1'b1) : a;
      b_mag    = b_neg ? (~b + 1'b1) : b;

      div_zero = is_div && (b == '0);
      div_ovf  = is_div && ~funct[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      if (div_zero) begin
         special_res = is_rem ? a : '1;
      end else begin
         special_res = is_rem ? '0 : a;
      end

      // Remainder takes the dividend sign; everything else the sign product
      neg_init    = (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
      sel_hi_init = is_div ? is_rem : (funct[1:0] != 2'd0);
   end

   // One iteration step, computed from the registered working state
   logic [WIDTH:0]     mul_sum, rem_sh, diff;
   logic [WIDTH-1:0]   step_hi, step_lo, lo_fix, hi_fix, calc_res;
   logic [2*WIDTH-1:0] prod, prod_fix;

   always_comb begin
      mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      // diff[WIDTH] set means the trial subtraction borrowed: restore
      diff    = rem_sh - {1'b0, mcand_q};
      if (is_div_q) begin
         step_hi = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end

      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? (~prod + 1'b1) : prod;
      lo_fix   = neg_q ? (~step_lo + 1'b1) : step_lo;
      hi_fix   = neg_q ? (~step_hi + 1'b1) : step_hi;
      if (is_div_q) begin
         calc_res = sel_hi_q ? hi_fix : lo_fix;
      end else begin
         calc_res = sel_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         mcand_q     <= '0;
         neg_q       <= 1'b0;
         is_div_q    <= 1'b0;
         sel_hi_q    <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else if (bus.flush_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid_i) begin
                  busy_q <= 1'b1;
                  if (!bus.op_i[4]) begin
                     result_q    <= base_res;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else if (div_zero || div_ovf) begin
                     result_q    <= special_res;
                     dbz_q       <= div_zero;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     cnt_q    <= CntW'(WIDTH);
                     hi_q     <= '0;
                     // Divider shifts the dividend out of lo; multiplier the multiplier
                     lo_q     <= is_div ? a_mag : b_mag;
                     mcand_q  <= is_div ? b_mag : a_mag;
                     neg_q    <= neg_init;
                     is_div_q <= is_div;
                     sel_hi_q <= sel_hi_init;
                     state_q  <= StCalc;
                  end
               end
            end
            StCalc: begin
               hi_q  <= step_hi;
               lo_q  <= step_lo;
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  result_q    <= calc_res;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready_i) begin
                  out_valid_q <= 1'b0;
                  dbz_q       <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready_o    = (state_q == StIdle) && !bus.flush_i;
   assign bus.out_valid_o   = out_valid_q;
   assign bus.result_o      = result_q;
   assign bus.div_by_zero_o = dbz_q;
   assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_mdu_if #(.WIDTH(32)) bus ();

   alu_mdu #(.WIDTH(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, check latency/result/flag, optionally stall the consumer.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_dbz, input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      bus.in_valid_i  = 1'b1;
      bus.op_i        = op;
      bus.operand_a_i = a;
      bus.operand_b_i = b;
      @(posedge clk);
      #1;
      // Scramble inputs after accept: must not affect the result
      bus.in_valid_i  = 1'b0;
      bus.op_i        = 5'h00;
      bus.operand_a_i = 32'h1234_5678;
      bus.operand_b_i = 32'h0BAD_F00D;
      lat = 1;
      while (!bus.out_valid_o && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, 64'(bus.result_o), 64'(exp_res));
      check({tag, " dbz"}, 64'(bus.div_by_zero_o), 64'(exp_dbz));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, " hold valid"}, 64'(bus.out_valid_o), 64'd1);
         check({tag, " hold result"}, 64'(bus.result_o), 64'(exp_res));
         check({tag, " hold in_ready"}, 64'(bus.in_ready_o), 64'd0);
      end
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
      check({tag, " consumed"}, 64'(bus.out_valid_o), 64'd0);
      check({tag, " idle"}, 64'(bus.busy_o), 64'd0);
   endtask

   initial begin
      int seen;
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      bus.flush_i     = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.op_i        = 5'h00;
      bus.operand_a_i = '0;
      bus.operand_b_i = '0;
      bus.out_ready_i = 1'b0;
      #12;
      check("reset out_valid", 64'(bus.out_valid_o), 64'd0);
      check("reset result", 64'(bus.result_o), 64'd0);
      check("reset busy", 64'(bus.busy_o), 64'd0);
      check("reset dbz", 64'(bus.div_by_zero_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle in_ready", 64'(bus.in_ready_o), 64'd1);

      // Base ops
      run_op("ADD", 5'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0);
      run_op("SUB", 5'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 0);
      run_op("SLTU", 5'd3, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, 0);
      run_op("SLT", 5'd2, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);
      run_op("SLTU b0", 5'd3, 32'd1, 32'd0, 32'd0, 1'b0, 1, 0);
      run_op("XOR", 5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 0);
      run_op("AND", 5'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0);
      run_op("SLL", 5'd7, 32'd1, 32'h0000_0021, 32'd2, 1'b0, 1, 0);
      run_op("SRL", 5'd8, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1, 0);
      run_op("SRA", 5'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 0);
      run_op("LUI", 5'd12, 32'd9, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1, 0);

      // Multiply
      run_op("MUL", 5'h10, 32'd7, 32'd6, 32'd42, 1'b0, 33, 0);
      run_op("MUL op3", 5'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33, 0);
      run_op("MULH", 5'h11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 0);
      run_op("MULHSU", 5'h12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 0);
      run_op("MULHU", 5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0);

      // Divide
      run_op("DIV", 5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 0);
      run_op("REM", 5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 0);
      run_op("DIVU", 5'h15, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0);
      run_op("REMU", 5'h17, 32'd100, 32'd7, 32'd2, 1'b0, 33, 0);
      run_op("DIVU zero", 5'h15, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 0);
      run_op("REM zero", 5'h16, 32'd5, 32'd0, 32'd5, 1'b1, 1, 0);
      run_op("DIV ovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0);
      run_op("REM ovf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);

      // Consumer stall in DONE
      run_op("MUL hold", 5'h10, 32'd7, 32'd6, 32'd42, 1'b0, 33, 5);

      // Flush mid-CALC with a competing request
      @(negedge clk);
      bus.in_valid_i  = 1'b1;
      bus.op_i        = 5'h15;
      bus.operand_a_i = 32'd100;
      bus.operand_b_i = 32'd7;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush_i     = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.op_i        = 5'd0;
      check("flush in_ready", 64'(bus.in_ready_o), 64'd0);
      @(posedge clk);
      #1;
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      check("flush busy", 64'(bus.busy_o), 64'd0);
      check("flush out_valid", 64'(bus.out_valid_o), 64'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid_o) seen = 1;
      end
      check("flush no result", 64'(seen), 64'd0);

      // Reset mid-CALC: outputs clear without a clock edge
      @(negedge clk);
      bus.in_valid_i  = 1'b1;
      bus.op_i        = 5'h10;
      bus.operand_a_i = 32'd7;
      bus.operand_b_i = 32'd6;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst busy", 64'(bus.busy_o), 64'd0);
      check("rst out_valid", 64'(bus.out_valid_o), 64'd0);
      check("rst result", 64'(bus.result_o), 64'd0);
      // Request presented while in reset; accepted at first edge after release
      bus.in_valid_i  = 1'b1;
      bus.op_i        = 5'd0;
      bus.operand_a_i = 32'd2;
      bus.operand_b_i = 32'd3;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      check("post-rst valid", 64'(bus.out_valid_o), 64'd1);
      check("post-rst result", 64'(bus.result_o), 64'd5);
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid_o) seen = 1;
      end
      check("rst no stale result", 64'(seen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
